// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: one-command-at-a-time front-end for a 4-bit ALU with an
// internal accumulator. Commands arrive on a valid/ready channel, execute
// against the accumulator, and the registered result leaves on a
// valid/ready response channel. The FSM runs IDLE -> EXEC -> RESP.
// Optional feature macro: ALU_SEQ_OVF_EN adds the rsp_ovf port and a
// registered signed-overflow flag.
module alu_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic             rsp_zero
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic             rsp_ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_ADDC = 3'd5,
    OP_SUBB = 3'd6,
    OP_READ = 3'd7
  } op_e;

  state_e           r_state;
  state_e           w_state_nxt;

  // Command captured at accept; the ALU works from these, not the live inputs.
  op_e              r_op;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;

  // Architectural state: accumulator plus flags.
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             r_zero;

  logic             w_cin;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_carry_nxt;

`ifdef ALU_SEQ_OVF_EN
  logic             r_ovf;
  logic             w_ovf_nxt;
  logic             w_add_ovf;
  logic             w_sub_ovf;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: one command in flight, EXEC is always a single cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the command on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= OP_LOAD;
      r_b   <= '0;
      r_cin <= 1'b0;
    end else if (r_state == S_IDLE && cmd_valid) begin
      r_op  <= op_e'(cmd_op);
      r_b   <= cmd_b;
      r_cin <= cmd_cin;
    end
  end

  // ALU: WIDTH+1-bit add/subtract so the top bit is carry or borrow.
  always_comb begin
    w_cin = (r_op == OP_ADDC || r_op == OP_SUBB) ? r_carry : r_cin;
    w_add = {1'b0, r_acc} + {1'b0, r_b} + {{WIDTH{1'b0}}, w_cin};
    w_sub = {1'b0, r_acc} - {1'b0, r_b} - {{WIDTH{1'b0}}, w_cin};
    w_acc_nxt   = r_acc;
    w_carry_nxt = r_carry;
    case (r_op)
      OP_LOAD: begin
        w_acc_nxt   = r_b;
        w_carry_nxt = 1'b0;
      end
      OP_ADD, OP_ADDC: begin
        w_acc_nxt   = w_add[WIDTH-1:0];
        w_carry_nxt = w_add[WIDTH];
      end
      OP_SUB, OP_SUBB: begin
        w_acc_nxt   = w_sub[WIDTH-1:0];
        w_carry_nxt = w_sub[WIDTH];
      end
      OP_NAND: begin
        w_acc_nxt   = ~(r_acc & r_b);
        w_carry_nxt = 1'b0;
      end
      OP_NOR: begin
        w_acc_nxt   = ~(r_acc | r_b);
        w_carry_nxt = 1'b0;
      end
      default: begin
        w_acc_nxt   = r_acc;
        w_carry_nxt = r_carry;
      end
    endcase
  end

`ifdef ALU_SEQ_OVF_EN
  // Signed overflow from operand/result sign bits; READ keeps the old flag.
  always_comb begin
    w_add_ovf = (r_acc[WIDTH-1] == r_b[WIDTH-1]) &&
                (w_add[WIDTH-1] != r_acc[WIDTH-1]);
    w_sub_ovf = (r_acc[WIDTH-1] != r_b[WIDTH-1]) &&
                (w_sub[WIDTH-1] != r_acc[WIDTH-1]);
    w_ovf_nxt = 1'b0;
    case (r_op)
      OP_ADD, OP_ADDC: w_ovf_nxt = w_add_ovf;
      OP_SUB, OP_SUBB: w_ovf_nxt = w_sub_ovf;
      OP_READ:         w_ovf_nxt = r_ovf;
      default:         w_ovf_nxt = 1'b0;
    endcase
  end

  // Overflow flag register, written only in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign rsp_ovf = r_ovf;
`endif

  // Accumulator and flags update once per command, in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b1;
    end else if (r_state == S_EXEC) begin
      r_acc   <= w_acc_nxt;
      r_carry <= w_carry_nxt;
      r_zero  <= (w_acc_nxt == '0);
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_data  = r_acc;
  assign rsp_cout  = r_carry;
  assign rsp_zero  = r_zero;

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequential command front-end for the 4-bit ALU datapath (add, subtract, NAND, NOR) with an internal accumulator. It accepts one command at a time over a valid/ready channel, executes it against the accumulator, updates carry and zero flags, and returns the result over a valid/ready response channel. It is the initiator side of the ALU operand/result interface: it sources operands and carry-in, then consumes the result and carry-out.

## Interface
- `WIDTH`, 4: datapath and accumulator width. Only 4 is verified.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command.
- `cmd_op` input 3: 0 LOAD, 1 ADD, 2 SUB, 3 NAND, 4 NOR, 5 ADDC, 6 SUBB, 7 READ.
- `cmd_b` input WIDTH: second operand. The accumulator is always operand a.
- `cmd_cin` input 1: carry/borrow-in for ADD and SUB.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_data` output WIDTH: accumulator value after the command.
- `rsp_cout` output 1: carry flag after the command.
- `rsp_zero` output 1: 1 when `rsp_data == 0`.
- `rsp_ovf` output 1: signed overflow flag. Present only with `ALU_SEQ_OVF_EN`.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - `cmd_ready` = 1.
  - When `cmd_valid` is high, capture `cmd_op`, `cmd_b`, `cmd_cin` and go to EXEC.
- EXEC:
  - `cmd_ready` = 0 and `rsp_valid` = 0.
  - Compute the result and register the accumulator and flags.
  - Go to RESP.
- RESP:
  - `rsp_valid` = 1. `rsp_*` outputs come from registers and stay stable.
  - When `rsp_ready` is high, go to IDLE.
- Arithmetic is done at WIDTH+1 bits; bit WIDTH becomes the carry flag:
  - ADD: {c, acc} = acc + b + cin.
  - SUB: {c, acc} = acc − b − cin, taken mod 2^(WIDTH+1). Here c = 1 means a borrow occurred (acc < b + cin).
  - ADDC: same as ADD, but cin is the stored carry flag and `cmd_cin` is ignored.
  - SUBB: same as SUB, but cin is the stored carry flag and `cmd_cin` is ignored.
  - NAND: acc = ~(acc & b); c = 0.
  - NOR: acc = ~(acc | b); c = 0.
  - LOAD: acc = b; c = 0.
  - READ: acc and c unchanged.
- The zero flag is recomputed after every command, READ included.
- `cmd_valid` seen while not in IDLE is ignored and produces no acceptance.

## Timing
- Command accepted at edge N; `rsp_valid` rises after edge N+1 (visible in cycle N+2). `rsp_data` and flags are valid in that same cycle.
- Minimum interval between accepted commands is 3 cycles.
- `cmd_ready` rises again in the cycle after the response handshake edge. There is no cmd/rsp overlap.
- Backpressure: `rsp_ready` low holds RESP indefinitely with all outputs stable.
- Reset values:
  - `cmd_ready` = 1, `rsp_valid` = 0.
  - `rsp_data` = 0, `rsp_cout` = 0, `rsp_zero` = 1, `rsp_ovf` = 0.
  - Accumulator = 0, carry flag = 0.
- Asserting `rst_n` low in any state, including mid-EXEC or RESP, immediately forces reset values and discards the in-flight command and response.
- Deassertion of `rst_n` is synchronised externally. The first accept can occur at the first edge after release.

## Configuration
- `ALU_SEQ_OVF_EN` defined:
  - The `rsp_ovf` port and a registered signed-overflow flag exist.
  - For ADD/ADDC: ovf = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]).
  - For SUB/SUBB: ovf = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]).
  - For LOAD/NAND/NOR: ovf is cleared.
  - For READ: ovf is unchanged.
- `ALU_SEQ_OVF_EN` undefined: no `rsp_ovf` port and no overflow logic. All other behaviour is identical.

## Test plan
- Load then add: LOAD b=0011, then ADD b=0101 cin=0 → rsp_data=1000, cout=0, zero=0. Response appears 2 cycles after each accept.
- Carry out on add: LOAD 1111, then ADD b=0001 cin=1 → rsp_data=0001, cout=1. Follow with ADDC b=0000 → rsp_data=0010, cout=0.
- Subtract without and with borrow:
  - LOAD 1001, SUB b=0011 cin=0 → 0110, cout=0.
  - LOAD 0011, SUB b=0101 cin=0 → 1110, cout=1.
  - Then SUBB b=0000 → 1101, cout=0.
- Logic ops and zero flag:
  - LOAD 1100, NAND b=1010 → 0111, cout=0.
  - LOAD 1100, NOR b=1010 → 0001.
  - LOAD 0000, READ → rsp_data=0000, zero=1.
- Backpressure and reset:
  - Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid` and data stay stable, `cmd_ready`=0, extra `cmd_valid` is not accepted.
  - Pulse `rst_n` low during EXEC → outputs go to reset values immediately, no response is emitted, and a following READ returns 0000 with zero=1.
- With `ALU_SEQ_OVF_EN`: LOAD 0111, ADD b=0001 cin=0 → 1000, ovf=1. LOAD 1000, SUB b=0001 → 0111, ovf=1.
